// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - ALU select codes, FSM state encoding and single-cycle op helper
package alu_exec_pkg;

    localparam int ALU_SHAMT_W = 5;

    localparam logic [4:0] ALU_NONE = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_XOR  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_AND  = 5'd4;
    localparam logic [4:0] ALU_SLT  = 5'd5;
    localparam logic [4:0] ALU_SLTU = 5'd6;
    localparam logic [4:0] ALU_SLL  = 5'd7;
    localparam logic [4:0] ALU_SRL  = 5'd8;
    localparam logic [4:0] ALU_SRA  = 5'd9;
    localparam logic [4:0] ALU_LUI  = 5'd10;

    typedef enum logic [1:0] {
        ALUX_IDLE  = 2'd0,
        ALUX_SHIFT = 2'd1,
        ALUX_DONE  = 2'd2
    } alux_state_e;

    function automatic logic is_shift(input logic [4:0] sel);
        return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
    endfunction

    // Shifts only reach this path with a zero shift amount, so they pass op1 through.
    function automatic logic [31:0] alu_single(input logic [4:0] sel,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        case (sel)
            ALU_ADD:  return a + b;
            ALU_XOR:  return a ^ b;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  return a;
            ALU_LUI:  return {a[19:0], 12'b0};
            default:  return 32'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - iterative shifter moving at most SHIFT_STEP bit positions per cycle
module alu_shifter
    import alu_exec_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   clear,
    input  logic                   dir_right,
    input  logic                   arith,
    input  logic [ALU_SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]       data,
    output logic [WIDTH-1:0]       data_next,
    output logic                   done
);

    localparam logic [ALU_SHAMT_W-1:0] STEP_W = ALU_SHAMT_W'(SHIFT_STEP);

    logic [WIDTH-1:0]       data_q;
    logic [ALU_SHAMT_W-1:0] count_q;
    logic [ALU_SHAMT_W-1:0] step;
    logic                   dir_q;
    logic                   arith_q;

    assign step = (count_q < STEP_W) ? count_q : STEP_W;

    always_comb begin
        data_next = data_q << step;
        if (dir_q) begin
            if (arith_q) data_next = WIDTH'($signed(data_q) >>> step);
            else         data_next = data_q >> step;
        end
    end

    // Asserted on the cycle whose step finishes the shift, so the caller can take data_next.
    assign done = (count_q != '0) && (count_q <= STEP_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            count_q <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else if (clear) begin
            count_q <= '0;
        end else if (load) begin
            data_q  <= data;
            count_q <= shamt;
            dir_q   <= dir_right;
            arith_q <= arith;
        end else if (count_q != '0) begin
            data_q  <= data_next;
            count_q <= count_q - step;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - execute-stage ALU with valid/ready handshake and iterative shifts
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [4:0]       alu_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    alux_state_e            state_q, state_d;
    logic [WIDTH-1:0]       result_q;
    logic [WIDTH-1:0]       sh_data_next;
    logic                   sh_done;
    logic                   accept;
    logic                   start_shift;
    logic [ALU_SHAMT_W-1:0] shamt;

    assign shamt       = op2[ALU_SHAMT_W-1:0];
    assign accept      = in_valid && in_ready && !flush;
    assign start_shift = accept && is_shift(alu_sel) && (shamt != '0);

    alu_shifter #(
        .WIDTH      (WIDTH),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (start_shift),
        .clear     (flush),
        .dir_right (alu_sel != ALU_SLL),
        .arith     (alu_sel == ALU_SRA),
        .shamt     (shamt),
        .data      (op1),
        .data_next (sh_data_next),
        .done      (sh_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ALUX_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            ALUX_IDLE: begin
                in_ready = 1'b1;
                if (accept) state_d = start_shift ? ALUX_SHIFT : ALUX_DONE;
            end
            ALUX_SHIFT: begin
                if (flush)        state_d = ALUX_IDLE;
                else if (sh_done) state_d = ALUX_DONE;
            end
            ALUX_DONE: begin
                // Consumer draining the result frees the slot in the same cycle.
                in_ready = out_ready;
                if (flush)          state_d = ALUX_IDLE;
                else if (accept)    state_d = start_shift ? ALUX_SHIFT : ALUX_DONE;
                else if (out_ready) state_d = ALUX_IDLE;
            end
            default: state_d = ALUX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else if (accept && !start_shift) begin
            result_q <= alu_single(alu_sel, op1, op2);
        end else if (state_q == ALUX_SHIFT && sh_done && !flush) begin
            result_q <= sh_data_next;
        end
    end

    assign out_valid = (state_q == ALUX_DONE);
    assign result    = result_q;
    assign zero      = (result_q == '0);

endmodule
